odd_parity_frame_receiver: RTL

//  Serial front end for the odd-parity checker stage. Deserialises one framed

---
 rtl/parity_pkg.sv | 16 +
 rtl/bit_tick_counter.sv | 34 +++
 rtl/odd_parity_frame_receiver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and defaults for the odd-parity serial front end.
// Imported by the frame receiver and its bit tick counter.
package parity_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_W_DEF       = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer: pulses tick after a full or half bit period.
// Wraps to zero on every tick; clr holds it at zero.
import parity_pkg::*;

module bit_tick_counter #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic half,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == (half ? HALF_LAST : FULL_LAST));

    // count cycles within the current bit period
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/odd_parity_frame_receiver.sv
// Serial frame receiver: start, LSB-first data, odd parity, stop.
// Presents data/p with a valid strobe and a local parity-error flag.
import parity_pkg::*;

module odd_parity_frame_receiver #(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              p,
    output logic              valid,
    output logic              pec,
    output logic              frame_err,
    output logic              busy
);

    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    logic              rx_m;
    logic              rx_s;
    state_t            state;
    state_t            state_nxt;
    logic              cnt_clr;
    logic              half;
    logic              tick;
    logic              samp_data;
    logic              samp_par;
    logic              samp_stop;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shift;
    logic              p_r;

    bit_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .half (half),
        .tick (tick)
    );

    assign half = (state == START);
    assign busy = (state != IDLE);

    // two-flop synchroniser, idle-high so reset does not fake a start
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and per-cycle sample strobes
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        samp_data = 1'b0;
        samp_par  = 1'b0;
        samp_stop = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (tick) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    samp_data = 1'b1;
                    if (idx == LAST_IDX) state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (tick) begin
                    samp_par  = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    samp_stop = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // deserialise: LSB arrives first and ends up in shift[0]
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            shift <= '0;
            p_r   <= 1'b0;
        end else begin
            if (state != DATA) idx <= '0;
            if (samp_data) begin
                shift <= {rx_s, shift[DATA_W-1:1]};
                idx   <= idx + IW'(1);
            end
            if (samp_par) p_r <= rx_s;
        end
    end

    // publish the frame on the stop-bit sample; hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            p         <= 1'b0;
            pec       <= 1'b0;
            frame_err <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= samp_stop;
            if (samp_stop) begin
                data      <= shift;
                p         <= p_r;
                pec       <= ~^{shift, p_r};
                frame_err <= ~rx_s;
            end
        end
    end

endmodule
